// File: rtl/alu_seq_ctrl.sv
// Switch-bus sequencer for the board ALU: loads A, then B, then the opcode, waits
// ALU_LAT settle cycles, then captures the result and status flags.
module alu_seq_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      sw,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             btn_go,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_out,
  input  logic [3:0]       alu_flags,
  output logic [31:0]      result,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             seq_err,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HAVE_A, S_HAVE_B, S_EXEC} state_t;

  localparam logic [4:0] LAT_M1 = 5'(ALU_LAT - 1);

  state_t           r_state, w_nxt;
  logic             r_ha, r_hb, r_hg;
  logic [4:0]       r_ecnt;
  logic [31:0]      r_alu_a, r_alu_b, r_result;
  logic [3:0]       r_alu_op, r_flags;
  logic             r_busy, r_done, r_seq_err;
  logic [CNT_W-1:0] r_op_cnt;

  logic w_rb, w_ea, w_eb, w_eg;
  logic w_ld_a, w_ld_b, w_go, w_cap, w_set_err;

  // Rising edges, a > b > go; lower-priority edges in the same cycle are dropped.
  assign w_rb = btn_b & ~r_hb;
  assign w_ea = btn_a & ~r_ha;
  assign w_eb = w_rb & ~w_ea;
  assign w_eg = btn_go & ~r_hg & ~w_ea & ~w_rb;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_ea) w_nxt = S_HAVE_A;
      S_HAVE_A: if (w_eb) w_nxt = S_HAVE_B;
      S_HAVE_B: begin
        if (w_ea)      w_nxt = S_HAVE_A;
        else if (w_eg) w_nxt = S_EXEC;
      end
      S_EXEC:   if (r_ecnt == 5'd0) w_nxt = S_HAVE_B;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld_a    = w_ea && (r_state != S_EXEC);
    w_ld_b    = w_eb && ((r_state == S_HAVE_A) || (r_state == S_HAVE_B));
    w_go      = w_eg && (r_state == S_HAVE_B);
    w_cap     = (r_state == S_EXEC) && (r_ecnt == 5'd0);
    w_set_err = ((r_state == S_IDLE) && (w_eb || w_eg)) ||
                ((r_state == S_HAVE_A) && w_eg);
  end

  // Histories load the live button level in reset so a held button is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ha      <= btn_a;
      r_hb      <= btn_b;
      r_hg      <= btn_go;
      r_ecnt    <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_op_cnt  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_ha   <= btn_a;
      r_hb   <= btn_b;
      r_hg   <= btn_go;
      r_busy <= (w_nxt == S_EXEC);
      r_done <= w_cap;
      if (w_ld_a) r_alu_a <= sw;
      if (w_ld_b) r_alu_b <= sw;
      if (w_go) begin
        r_alu_op <= sw[3:0];
        r_ecnt   <= LAT_M1;
      end else if ((r_state == S_EXEC) && (r_ecnt != 5'd0)) begin
        r_ecnt <= r_ecnt - 5'd1;
      end
      if (w_cap) begin
        r_result <= alu_out;
        r_flags  <= alu_flags;
        r_op_cnt <= r_op_cnt + 1'b1;
      end
      if (w_ld_a)         r_seq_err <= 1'b0;
      else if (w_set_err) r_seq_err <= 1'b1;
    end
  end

  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign alu_op  = r_alu_op;
  assign result  = r_result;
  assign flags   = r_flags;
  assign busy    = r_busy;
  assign done    = r_done;
  assign seq_err = r_seq_err;
  assign op_cnt  = r_op_cnt;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: two instances (ALU_LAT=1/CNT_W=2 and ALU_LAT=4/CNT_W=8),
// each driving a behavioural ALU; expected captures are queued at go time.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic [31:0] r;
    logic [3:0]  f;
    logic [7:0]  c;
  } exp_t;

  exp_t sb[$];
  int   errs = 0, checks = 0;
  int   n_done[2] = '{0, 0};
  int   bcnt[2]   = '{0, 0};
  int   ncnt[2]   = '{0, 0};
  int   lat[2]    = '{1, 4};

  logic        rst[2], ba[2], bb[2], bg[2];
  logic [31:0] sw[2], aa[2], ab[2], ao[2], res[2];
  logic [3:0]  aop[2], af[2], flg[2];
  logic        busy[2], done[2], serr[2];
  logic [7:0]  opc[2];
  logic [1:0]  opc0;
  logic [7:0]  opc1;

  // {ZF,CF,OF,SF, result}; CF is carry for ADD and borrow for SUB.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] t;
    logic [31:0] r;
    logic        cf, of;
    t = '0; cf = 1'b0; of = 1'b0;
    case (op)
      4'd0: begin
        t = {1'b0, a} + {1'b0, b}; r = t[31:0]; cf = t[32];
        of = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        t = {1'b0, a} - {1'b0, b}; r = t[31:0]; cf = t[32];
        of = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      default: r = a;
    endcase
    return {(r == 32'd0), cf, of, r[31], r};
  endfunction

  assign {af[0], ao[0]} = alu_f(aa[0], ab[0], aop[0]);
  assign {af[1], ao[1]} = alu_f(aa[1], ab[1], aop[1]);
  assign opc[0] = {6'd0, opc0};
  assign opc[1] = opc1;

  alu_seq_ctrl #(.ALU_LAT(1), .CNT_W(2)) u_l1 (
    .clk(clk), .rst(rst[0]), .sw(sw[0]), .btn_a(ba[0]), .btn_b(bb[0]), .btn_go(bg[0]),
    .alu_a(aa[0]), .alu_b(ab[0]), .alu_op(aop[0]), .alu_out(ao[0]), .alu_flags(af[0]),
    .result(res[0]), .flags(flg[0]), .busy(busy[0]), .done(done[0]),
    .seq_err(serr[0]), .op_cnt(opc0));

  alu_seq_ctrl #(.ALU_LAT(4), .CNT_W(8)) u_l4 (
    .clk(clk), .rst(rst[1]), .sw(sw[1]), .btn_a(ba[1]), .btn_b(bb[1]), .btn_go(bg[1]),
    .alu_a(aa[1]), .alu_b(ab[1]), .alu_op(aop[1]), .alu_out(ao[1]), .alu_flags(af[1]),
    .result(res[1]), .flags(flg[1]), .busy(busy[1]), .done(done[1]),
    .seq_err(serr[1]), .op_cnt(opc1));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input int d, input bit a, input bit b, input bit g,
                       input logic [31:0] v);
    sw[d] = v; ba[d] = a; bb[d] = b; bg[d] = g;
    tick();
    ba[d] = 1'b0; bb[d] = 1'b0; bg[d] = 1'b0;
    tick();
  endtask

  task automatic rst_dut(input int d);
    rst[d] = 1'b1;
    sb.delete();
    ncnt[d] = 0;
    tick(); tick();
    rst[d] = 1'b0;
  endtask

  // Issue an op on operands the bench believes are loaded; optionally poke btn_a mid-exec.
  task automatic go(input int d, input logic [3:0] op, input logic [31:0] a,
                    input logic [31:0] b, input bit poke);
    logic [35:0] e;
    int n0;
    e = alu_f(a, b, op);
    ncnt[d] = (ncnt[d] + 1) & ((d == 0) ? 3 : 255);
    sb.push_back('{d, e[31:0], e[35:32], 8'(ncnt[d])});
    n0 = n_done[d];
    press(d, 1'b0, 1'b0, 1'b1, {28'h0, op});
    if (poke) press(d, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 40 && n_done[d] == n0; i++) tick();
    chk("done_seen", 64'(n_done[d] != n0), 64'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) bcnt[d] = 0;
      else begin
        if (busy[d]) bcnt[d]++;
        if (done[d]) begin
          n_done[d]++;
          if (sb.size() == 0) chk("unexp_done", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("sb_inst", 64'(d), 64'(e.d));
            chk("result", res[d], e.r);
            chk("flags", flg[d], e.f);
            chk("op_cnt", opc[d], e.c);
            chk("busy_len", 64'(bcnt[d]), 64'(lat[d]));
          end
          bcnt[d] = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ba[d] = 1'b0; bb[d] = 1'b0; bg[d] = 1'b0; sw[d] = '0;
    end
    ba[0] = 1'b1; sw[0] = 32'h55;
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick(); tick();
    chk("held_a_no_edge", aa[0], 32'h0);
    ba[0] = 1'b0;
    tick();

    chk("rst_alu_a", aa[1], 32'h0);
    chk("rst_alu_b", ab[1], 32'h0);
    chk("rst_alu_op", aop[1], 4'h0);
    chk("rst_result", res[1], 32'h0);
    chk("rst_flags", flg[1], 4'h0);
    chk("rst_op_cnt", opc[1], 8'h0);
    chk("rst_busy", busy[1], 1'b0);
    chk("rst_done", done[1], 1'b0);
    chk("rst_seq_err", serr[1], 1'b0);

    // Nominal add, ALU_LAT=1
    press(0, 1'b1, 1'b0, 1'b0, 32'd5);
    press(0, 1'b0, 1'b1, 1'b0, 32'd3);
    go(0, 4'd0, 32'd5, 32'd3, 1'b0);
    chk("done_single", done[0], 1'b0);
    chk("nom_seq_err", serr[0], 1'b0);
    tick(); tick(); tick();
    chk("result_held", res[0], 32'd8);

    // Ordering errors
    press(1, 1'b0, 1'b1, 1'b0, 32'd7);
    chk("b_first_err", serr[1], 1'b1);
    chk("b_first_noload", ab[1], 32'h0);
    n0 = n_done[1];
    press(1, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("go_first_err", serr[1], 1'b1);
    chk("go_first_nodone", 64'(n_done[1]), 64'(n0));
    press(1, 1'b1, 1'b0, 1'b0, 32'd9);
    chk("a_load", aa[1], 32'd9);
    chk("a_clr_err", serr[1], 1'b0);

    // Re-execute, zero flag, ALU_LAT=4
    press(1, 1'b1, 1'b0, 1'b0, 32'd6);
    press(1, 1'b0, 1'b1, 1'b0, 32'd6);
    go(1, 4'd0, 32'd6, 32'd6, 1'b0);
    go(1, 4'd1, 32'd6, 32'd6, 1'b0);
    chk("zf_flags", flg[1], 4'b1000);
    chk("reexec_a", aa[1], 32'd6);
    chk("reexec_b", ab[1], 32'd6);

    // Button edges ignored during exec
    go(1, 4'd0, 32'd6, 32'd6, 1'b1);
    tick(); tick(); tick();
    chk("exec_ignore_a", aa[1], 32'd6);

    // a and go together in S_HAVE_B: only a wins
    n0 = n_done[1];
    press(1, 1'b1, 1'b0, 1'b1, 32'h11);
    chk("prio_a_load", aa[1], 32'h11);
    chk("prio_busy", busy[1], 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("prio_nodone", 64'(n_done[1]), 64'(n0));
    press(1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("prio_state_a", serr[1], 1'b1);
    press(1, 1'b0, 1'b1, 1'b0, 32'd4);

    // Reset in the 2nd exec cycle
    n0 = n_done[1];
    press(1, 1'b0, 1'b0, 1'b1, 32'h0);
    rst[1] = 1'b1;
    ncnt[1] = 0;
    tick();
    rst[1] = 1'b0;
    chk("mid_rst_result", res[1], 32'h0);
    chk("mid_rst_op_cnt", opc[1], 8'h0);
    chk("mid_rst_busy", busy[1], 1'b0);
    chk("mid_rst_alu_a", aa[1], 32'h0);
    for (int i = 0; i < 6; i++) tick();
    chk("mid_rst_nodone", 64'(n_done[1]), 64'(n0));
    press(1, 1'b0, 1'b1, 1'b0, 32'd1);
    chk("mid_rst_idle", serr[1], 1'b1);

    // op_cnt wrap with CNT_W=2
    rst_dut(0);
    press(0, 1'b1, 1'b0, 1'b0, 32'h0F0F);
    press(0, 1'b0, 1'b1, 1'b0, 32'h00FF);
    go(0, 4'd2, 32'h0F0F, 32'h00FF, 1'b0);
    go(0, 4'd3, 32'h0F0F, 32'h00FF, 1'b0);
    go(0, 4'd4, 32'h0F0F, 32'h00FF, 1'b0);
    press(0, 1'b0, 1'b1, 1'b0, 32'h0001_0000);
    go(0, 4'd1, 32'h0F0F, 32'h0001_0000, 1'b0);
    chk("wrap_cnt", opc[0], 8'h0);

    tick(); tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Single-clock sequencer that drives the ALU operand and opcode inputs from the shared 32-bit switch bus, replacing the separate per-register load clocks.
- Loads operand A, then operand B, then issues the operation. It waits a programmable settle time, then captures the result and the four status flags.
- Sits between the board inputs (switches, buttons) and the combinational ALU. It feeds the result register to the 7-segment LED driver and the flags to the status LEDs.

Parameters:
- ALU_LAT, 1, settle cycles between applying operands/op and capturing the result; legal range 1..16.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sw  in  32  switch bus; operand source; sw[3:0] is the opcode source.
- btn_a  in  1  load-A button level, already synchronised to clk.
- btn_b  in  1  load-B button level, synchronised.
- btn_go  in  1  execute button level, synchronised.
- alu_a  out  32  operand A to ALU.
- alu_b  out  32  operand B to ALU.
- alu_op  out  4  opcode to ALU.
- alu_out  in  32  ALU result.
- alu_flags  in  4  {ZF,CF,OF,SF} from ALU.
- result  out  32  captured result.
- flags  out  4  captured {ZF,CF,OF,SF}.
- busy  out  1  high while in S_EXEC.
- done  out  1  one-cycle pulse on capture.
- seq_err  out  1  sticky sequencing-error flag.
- op_cnt  out  CNT_W  completed operations, wraps.

Behaviour:
- Reset (rst high at a clk edge): state S_IDLE; alu_a, alu_b, alu_op, result, flags, op_cnt, exec counter all 0; busy=0, done=0, seq_err=0.
- Reset also loads each button-history register with the current button level, so a button held through reset produces no edge.
- Edge detect: an edge is button high now and history low. The action takes effect at that same clk edge. History updates every cycle.
- Edge priority within a cycle is a > b > go. Lower-priority simultaneous edges are dropped silently, with no error.
- S_IDLE (no operands):
  - a-edge: alu_a<=sw, clear seq_err, go to S_HAVE_A.
  - b-edge or go-edge: seq_err<=1, no load, stay.
- S_HAVE_A:
  - a-edge: reload alu_a, clear seq_err.
  - b-edge: alu_b<=sw, go to S_HAVE_B.
  - go-edge: seq_err<=1, stay.
- S_HAVE_B:
  - a-edge: reload alu_a, clear seq_err, go to S_HAVE_A (B is invalidated but alu_b is held).
  - b-edge: reload alu_b.
  - go-edge: alu_op<=sw[3:0], exec counter<=ALU_LAT-1, go to S_EXEC.
- S_EXEC:
  - busy=1. alu_a, alu_b and alu_op are held stable. All button edges are ignored and not queued.
  - Counter decrements each cycle. At the edge where the counter is 0: result<=alu_out, flags<=alu_flags, op_cnt<=op_cnt+1 (mod 2^CNT_W), go to S_HAVE_B.
  - done=1 for exactly the cycle following the capture edge.
- busy is high for exactly ALU_LAT cycles per operation.
- Re-execution: from S_HAVE_B a new go-edge runs a new op on the same operands.
- result and flags change only at capture edges or reset. They are held between captures.
- rst mid-S_EXEC: no capture, no done pulse; all outputs return to reset values next cycle.
- busy and done are registered. No combinational path from any input to any output.

Test Plan:
- Nominal add (bench ALU model computes a+b, flags per result), ALU_LAT=1:
  - Stimulus: sw=5 + btn_a; sw=3 + btn_b; sw[3:0]=0 + btn_go.
  - Required: busy high 1 cycle; then result=8, flags=4'b0000, done single pulse, op_cnt=1, seq_err=0.
- Ordering errors:
  - Stimulus: after reset, btn_b with sw=7.
  - Required: seq_err=1, alu_b=0. Then btn_go keeps seq_err=1 and done never pulses. Then btn_a with sw=9 gives alu_a=9, seq_err=0.
- Re-execute and zero flag, ALU_LAT=4:
  - Stimulus: operands 6/6 loaded, go with ADD, then go with SUB opcode.
  - Required: busy 4 cycles each; second result=0, ZF=1; op_cnt=2; alu_a=6 and alu_b=6 unchanged.
- Ignore during exec:
  - Stimulus: ALU_LAT=4; pulse btn_a with sw=0xFFFF_FFFF in the 2nd S_EXEC cycle.
  - Required: alu_a unchanged, capture occurs on schedule, no load after exec ends.
- Edge cases:
  - Stimulus A: btn_a held high through reset release.
  - Required A: alu_a stays 0.
  - Stimulus B: in S_HAVE_B, btn_a and btn_go rise in the same cycle.
  - Required B: only alu_a reloads, state S_HAVE_A, busy stays 0.
- Reset/wrap:
  - Stimulus: rst asserted during the 2nd S_EXEC cycle (ALU_LAT=4).
  - Required: no done; next cycle result=0, op_cnt=0, state S_IDLE.
  - Stimulus: CNT_W=2, four completed ops.
  - Required: op_cnt reads 1,2,3,0.
